// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 active-low keypad scanner with debounce and 4-digit hex entry buffer
module keypad_scan #(
   parameter int SCAN_DIV = 16,
   parameter int DEBOUNCE = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        enter,
   output logic [15:0] passvalue,
   output logic [2:0]  digit_cnt
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;

   state_t          state, state_n;
   logic [3:0]      row_m, rs;
   logic [1:0]      ci, ci_n;
   logic [1:0]      ri, ri_n;
   logic [1:0]      row_idx;
   logic [DW-1:0]   div_q, div_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [3:0]      pat, pat_n;
   logic [3:0]      code;
   logic            kv_n, en_n;
   logic [3:0]      kc_n;
   logic [15:0]     pv_n;
   logic [2:0]      dc_n;

   assign col  = ~(4'b0001 << ci);
   assign code = {ri, ci};

   // Lowest-numbered active row wins when several rows are low.
   always_comb begin
      row_idx = 2'd3;
      if (!rs[0])      row_idx = 2'd0;
      else if (!rs[1]) row_idx = 2'd1;
      else if (!rs[2]) row_idx = 2'd2;
   end

   always_comb begin
      state_n = state;
      ci_n    = ci;
      ri_n    = ri;
      div_n   = div_q;
      cnt_n   = cnt;
      pat_n   = pat;
      kv_n    = 1'b0;
      en_n    = 1'b0;
      kc_n    = key_code;
      pv_n    = passvalue;
      dc_n    = digit_cnt;
      case (state)
         ST_SCAN: begin
            if (div_q == DIV_LAST) begin
               div_n = '0;
               if (rs == 4'hF) begin
                  ci_n = ci + 2'd1;
               end else begin
                  pat_n   = rs;
                  ri_n    = row_idx;
                  cnt_n   = '0;
                  state_n = ST_DEBOUNCE;
               end
            end else begin
               div_n = div_q + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (rs == pat) begin
               if (cnt == CNT_LAST) state_n = ST_PRESSED;
               else                 cnt_n   = cnt + 1'b1;
            end else begin
               state_n = ST_SCAN;
               ci_n    = ci + 2'd1;
               div_n   = '0;
            end
         end
         ST_PRESSED: begin
            kv_n    = 1'b1;
            kc_n    = code;
            en_n    = (code == 4'hA);
            state_n = ST_RELEASE;
            cnt_n   = '0;
            if (code <= 4'd9) begin
               if (digit_cnt < 3'd4) begin
                  pv_n = {passvalue[11:0], code};
                  dc_n = digit_cnt + 3'd1;
               end
            end else if (code == 4'hE) begin
               if (digit_cnt != 3'd0) begin
                  pv_n = {4'h0, passvalue[15:4]};
                  dc_n = digit_cnt - 3'd1;
               end
            end else if (code == 4'hF) begin
               pv_n = 16'h0;
               dc_n = 3'd0;
            end
         end
         ST_RELEASE: begin
            // Only an unbroken run of all-high rows counts as a release.
            if (rs == 4'hF) begin
               if (cnt == CNT_LAST) begin
                  state_n = ST_SCAN;
                  ci_n    = ci + 2'd1;
                  div_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end else begin
               cnt_n = '0;
            end
         end
         default: state_n = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_m     <= 4'hF;
         rs        <= 4'hF;
         state     <= ST_SCAN;
         ci        <= 2'd0;
         ri        <= 2'd0;
         div_q     <= '0;
         cnt       <= '0;
         pat       <= 4'hF;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         enter     <= 1'b0;
         passvalue <= 16'h0;
         digit_cnt <= 3'd0;
      end else begin
         row_m     <= row;
         rs        <= row_m;
         state     <= state_n;
         ci        <= ci_n;
         ri        <= ri_n;
         div_q     <= div_n;
         cnt       <= cnt_n;
         pat       <= pat_n;
         key_valid <= kv_n;
         key_code  <= kc_n;
         enter     <= en_n;
         passvalue <= pv_n;
         digit_cnt <= dc_n;
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan with keypad matrix emulation
module tb_keypad_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        enter;
   logic [15:0] passvalue;
   logic [2:0]  digit_cnt;

   logic        key_down = 1'b0;
   logic [1:0]  kr = 2'd0, kc = 2'd0;

   int n_checks = 0;
   int n_fail   = 0;
   int kv_count = 0;
   logic [3:0] last_code = 4'h0;
   logic       last_enter = 1'b0;
   logic       prev_kv = 1'b0;
   int model_q[$];

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
      .clk(clk), .rst(rst), .row(row), .col(col),
      .key_valid(key_valid), .key_code(key_code), .enter(enter),
      .passvalue(passvalue), .digit_cnt(digit_cnt)
   );

   always #5 clk = ~clk;

   // A pressed key shorts its row to its column, so the row reads low only while that column is driven.
   always_comb begin
      row = 4'hF;
      if (key_down && !col[kc]) row[kr] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_apply(input logic [3:0] c);
      if (c <= 4'd9) begin
         if (model_q.size() < 4) model_q.push_back(int'(c));
      end else if (c == 4'hE) begin
         if (model_q.size() > 0) void'(model_q.pop_back());
      end else if (c == 4'hF) begin
         model_q.delete();
      end
   endfunction

   function automatic logic [31:0] model_pv();
      int v = 0;
      foreach (model_q[i]) v = v * 16 + model_q[i];
      return 32'(v);
   endfunction

   always begin
      @(posedge clk);
      #1;
      if (key_valid || enter) begin
         check("enter_coincident", 32'(enter), 32'(key_valid && key_code == 4'hA));
         check("strobe_single_cycle", 32'(prev_kv), 32'd0);
      end
      if (key_valid) begin
         kv_count++;
         last_code  = key_code;
         last_enter = enter;
      end
      prev_kv = key_valid;
   end

   task automatic wait_strobe(input int base, input string name);
      int t = 0;
      while (kv_count == base && t < 200) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(kv_count - base), 32'd1);
   endtask

   task automatic press_key(input logic [3:0] code, input int hold);
      int base = kv_count;
      kr = code[3:2];
      kc = code[1:0];
      key_down = 1'b1;
      wait_strobe(base, "press_detected");
      repeat (hold) @(negedge clk);
      key_down = 1'b0;
      repeat (30) @(negedge clk);
      check("one_strobe_per_press", 32'(kv_count - base), 32'd1);
      check("key_code", 32'(last_code), 32'(code));
      check("enter_flag", 32'(last_enter), 32'(code == 4'hA));
      model_apply(code);
      check("passvalue_model", 32'(passvalue), model_pv());
      check("digit_cnt_model", 32'(digit_cnt), 32'(model_q.size()));
   endtask

   typedef struct {
      logic [3:0]  exp_col;
      logic        exp_kv;
      logic [15:0] exp_pv;
   } scan_vec_t;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] exp_pv;
      logic [2:0]  exp_dc;
   } dig_vec_t;

   scan_vec_t sv[5];
   dig_vec_t  dv[9];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      logic [3:0] rc;

      sv[0] = '{4'b1110, 1'b0, 16'h0};
      sv[1] = '{4'b1101, 1'b0, 16'h0};
      sv[2] = '{4'b1011, 1'b0, 16'h0};
      sv[3] = '{4'b0111, 1'b0, 16'h0};
      sv[4] = '{4'b1110, 1'b0, 16'h0};

      dv[0] = '{4'hF, 16'h0000, 3'd0};
      dv[1] = '{4'h1, 16'h0001, 3'd1};
      dv[2] = '{4'h2, 16'h0012, 3'd2};
      dv[3] = '{4'h3, 16'h0123, 3'd3};
      dv[4] = '{4'h4, 16'h1234, 3'd4};
      dv[5] = '{4'h5, 16'h1234, 3'd4};
      dv[6] = '{4'hE, 16'h0123, 3'd3};
      dv[7] = '{4'hF, 16'h0000, 3'd0};
      dv[8] = '{4'hE, 16'h0000, 3'd0};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_col", 32'(col), 32'hE);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_key_code", 32'(key_code), 32'd0);
      check("rst_enter", 32'(enter), 32'd0);
      check("rst_passvalue", 32'(passvalue), 32'd0);
      check("rst_digit_cnt", 32'(digit_cnt), 32'd0);
      rst = 1'b1;

      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) repeat (4) @(negedge clk);
         check("scan_col", 32'(col), 32'(sv[i].exp_col));
         check("scan_key_valid", 32'(key_valid), 32'(sv[i].exp_kv));
         check("scan_passvalue", 32'(passvalue), 32'(sv[i].exp_pv));
      end

      press_key(4'h6, 40);
      check("key6_passvalue", 32'(passvalue), 32'h0006);
      check("key6_digit_cnt", 32'(digit_cnt), 32'd1);

      for (int i = 0; i < 9; i++) begin
         press_key(dv[i].code, 5);
         check("digit_passvalue", 32'(passvalue), 32'(dv[i].exp_pv));
         check("digit_cnt", 32'(digit_cnt), 32'(dv[i].exp_dc));
      end

      // Bounce shorter than the debounce window must never produce a strobe.
      base = kv_count;
      kr = 2'd1;
      kc = 2'd3;
      for (int i = 0; i < 10; i++) begin
         key_down = ~key_down;
         repeat (3) @(negedge clk);
      end
      check("bounce_no_strobe", 32'(kv_count - base), 32'd0);
      press_key(4'h7, 10);
      check("bounce_then_stable", 32'(passvalue), 32'h0007);
      press_key(4'hA, 10);
      check("enter_passvalue_kept", 32'(passvalue), 32'h0007);

      press_key(4'hF, 3);
      press_key(4'h4, 3);
      press_key(4'h2, 3);
      check("pre_reset_passvalue", 32'(passvalue), 32'h0042);

      base = kv_count;
      kr = 2'd2;
      kc = 2'd3;
      key_down = 1'b1;
      wait_strobe(base, "held_key_first_strobe");
      repeat (3) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_rst_col", 32'(col), 32'h E);
      check("async_rst_key_valid", 32'(key_valid), 32'd0);
      check("async_rst_key_code", 32'(key_code), 32'd0);
      check("async_rst_enter", 32'(enter), 32'd0);
      check("async_rst_passvalue", 32'(passvalue), 32'd0);
      check("async_rst_digit_cnt", 32'(digit_cnt), 32'd0);
      model_q.delete();
      @(negedge clk);
      rst = 1'b1;
      base = kv_count;
      wait_strobe(base, "held_key_redetected");
      check("redetected_code", 32'(last_code), 32'h B);
      key_down = 1'b0;
      repeat (30) @(negedge clk);
      check("redetected_single", 32'(kv_count - base), 32'd1);
      check("post_reset_passvalue", 32'(passvalue), 32'd0);

      for (int i = 0; i < 25; i++) begin
         rc = 4'($urandom_range(0, 15));
         press_key(rc, int'($urandom_range(0, 40)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
